bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 130 +++++++++++++
 tb/tb_bus_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for a shared tri-state bus: grants one requester at a time,
// with setup (GRANT) and turnaround (RELEASE) cycles and a forced release after MAXHOLD cycles.
module bus_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned MAXHOLD = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ-1:0]         done_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [NREQ-1:0]         ldbus_o,
    output logic [$clog2(NREQ)-1:0] gnt_id_o,
    output logic                    busy_o,
    output logic                    timeout_o
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned HW  = 8;
    localparam logic [HW-1:0] HLIM = HW'(MAXHOLD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        OWN     = 2'd2,
        RELEASE = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  gnt_id_q, gnt_id_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] ldbus_q, ldbus_d;
    logic            busy_q, busy_d;
    logic            timeout_q, timeout_d;

    logic [IDW-1:0]  win_c, cand_c;
    logic            found_c;
    logic            own_req_c, own_done_c, at_limit_c;
    logic [NREQ-1:0] onehot_c;

    // Round-robin pick: first requester at or after ptr_q, wrapping
    always_comb begin
        found_c = 1'b0;
        win_c   = ptr_q;
        cand_c  = ptr_q;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand_c = IDW'((32'(ptr_q) + k) % NREQ);
            if (!found_c && req_i[cand_c]) begin
                found_c = 1'b1;
                win_c   = cand_c;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_id_d   = gnt_id_q;
        ptr_d      = ptr_q;
        hcnt_d     = hcnt_q;
        timeout_d  = 1'b0;
        own_req_c  = req_i[gnt_id_q];
        own_done_c = done_i[gnt_id_q];
        at_limit_c = (hcnt_q == HLIM);

        case (state_q)
            IDLE: begin
                if (found_c) begin
                    gnt_id_d = win_c;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                hcnt_d  = '0;
                state_d = own_req_c ? OWN : RELEASE;
            end
            OWN: begin
                if (own_done_c || !own_req_c || at_limit_c) begin
                    state_d   = RELEASE;
                    // Flag a timeout only when the hold limit alone ended the tenure
                    timeout_d = at_limit_c && own_req_c && !own_done_c;
                    hcnt_d    = '0;
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            RELEASE: begin
                ptr_d   = (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + IDW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are precomputed from the next state so they leave straight from flops
        onehot_c = NREQ'(1) << gnt_id_d;
        gnt_d    = (state_d == GRANT || state_d == OWN) ? onehot_c : '0;
        ldbus_d  = (state_d == OWN) ? onehot_c : '0;
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_id_q  <= '0;
            ptr_q     <= '0;
            hcnt_q    <= '0;
            gnt_q     <= '0;
            ldbus_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_id_q  <= gnt_id_d;
            ptr_q     <= ptr_d;
            hcnt_q    <= hcnt_d;
            gnt_q     <= gnt_d;
            ldbus_q   <= ldbus_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign ldbus_o   = ldbus_q;
    assign gnt_id_o  = gnt_id_q;
    assign busy_o    = busy_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: fixed vector table, directed corner sequences,
// and random traffic compared against a tenure-position reference model.
module tb_bus_arbiter;

    localparam int NREQ    = 4;
    localparam int MAXHOLD = 16;

    logic            clk;
    logic            rst_n;
    logic [NREQ-1:0] req_i;
    logic [NREQ-1:0] done_i;
    logic [NREQ-1:0] gnt_o;
    logic [NREQ-1:0] ldbus_o;
    logic [1:0]      gnt_id_o;
    logic            busy_o;
    logic            timeout_o;

    int n_cmp;
    int n_mis;

    bus_arbiter #(.NREQ(NREQ), .MAXHOLD(MAXHOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .done_i    (done_i),
        .gnt_o     (gnt_o),
        .ldbus_o   (ldbus_o),
        .gnt_id_o  (gnt_id_o),
        .busy_o    (busy_o),
        .timeout_o (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: m_pos 0 = idle, 1 = setup, 2.. = own cycle (m_pos-1), -1 = turnaround
    int m_pos;
    int m_owner;
    int m_ptr;
    bit m_to;

    task automatic model_reset();
        m_pos = 0; m_owner = 0; m_ptr = 0; m_to = 1'b0;
    endtask

    task automatic model_step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] d);
        int c;
        int i;
        m_to = 1'b0;
        if (m_pos == 0) begin
            if (r != '0) begin
                for (int k = 0; k < NREQ; k++) begin
                    i = (m_ptr + k) % NREQ;
                    if (r[i]) begin
                        m_owner = i;
                        break;
                    end
                end
                m_pos = 1;
            end
        end else if (m_pos == 1) begin
            m_pos = r[m_owner] ? 2 : -1;
        end else if (m_pos >= 2) begin
            c = m_pos - 1;
            if (d[m_owner] || !r[m_owner] || c == MAXHOLD) begin
                m_to  = (c == MAXHOLD) && r[m_owner] && !d[m_owner];
                m_pos = -1;
            end else begin
                m_pos = m_pos + 1;
            end
        end else begin
            m_ptr = (m_owner + 1) % NREQ;
            m_pos = 0;
        end
    endtask

    function automatic logic [31:0] pack_model();
        logic [NREQ-1:0] oh;
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] l;
        oh = 4'b0001 << m_owner;
        g  = (m_pos >= 1) ? oh : '0;
        l  = (m_pos >= 2) ? oh : '0;
        return {20'b0, g, l, 2'(m_owner), (m_pos != 0), m_to};
    endfunction

    function automatic logic [31:0] pack_dut();
        return {20'b0, gnt_o, ldbus_o, gnt_id_o, busy_o, timeout_o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input string name, input logic [NREQ-1:0] r, input logic [NREQ-1:0] d);
        req_i  = r;
        done_i = d;
        @(posedge clk);
        model_step(r, d);
        @(negedge clk);
        check(name, pack_dut(), pack_model());
        check("ldbus_onehot", 32'($countones(ldbus_o) <= 1), 32'd1);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        req_i  = '0;
        done_i = '0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("reset_state", pack_dut(), 32'd0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] gnt;
        logic [3:0] ld;
        logic [1:0] id;
        logic       busy;
        logic       to;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [NREQ-1:0] rr;
        logic [NREQ-1:0] dd;
        int owners[$];
        int last_ld;
        int ld_cnt;
        int to_cnt;

        n_cmp = 0;
        n_mis = 0;
        rst_n = 1'b0;
        req_i = '0;
        done_i = '0;

        // Single owner with DONE, pointer advance, GRANT abort, REQ drop in GRANT
        vecs[0]  = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0};
        vecs[1]  = '{4'b0010, 4'b0000, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[2]  = '{4'b0010, 4'b0000, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[3]  = '{4'b0010, 4'b0000, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[4]  = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0};
        vecs[5]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0};
        vecs[6]  = '{4'b1010, 4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b1, 1'b0};
        vecs[7]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b1, 1'b0};
        vecs[8]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0};
        vecs[9]  = '{4'b0110, 4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0};
        vecs[10] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0};
        vecs[11] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0};

        @(negedge clk);
        do_reset();
        foreach (vecs[i]) begin
            req_i  = vecs[i].req;
            done_i = vecs[i].done;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d", i), pack_dut(),
                  {20'b0, vecs[i].gnt, vecs[i].ld, vecs[i].id, vecs[i].busy, vecs[i].to});
        end

        // All requesting with DONE every cycle: strict rotation, 3-cycle LDBUS gap
        do_reset();
        last_ld = -1;
        for (int s = 1; s <= 20; s++) begin
            step("rotate", 4'b1111, 4'b1111);
            if (gnt_o != '0 && ldbus_o == '0) owners.push_back(int'(gnt_id_o));
            if (ldbus_o != '0) begin
                if (last_ld >= 0) check("rotate_gap", 32'(s - last_ld - 1), 32'd3);
                last_ld = s;
            end
        end
        check("rotate_count", 32'(owners.size()), 32'd5);
        foreach (owners[i]) check($sformatf("rotate_owner%0d", i), 32'(owners[i]), 32'(i % NREQ));

        // Sole requester holds past the limit: 16 LDBUS cycles, one TIMEOUT, regrant
        do_reset();
        ld_cnt = 0;
        to_cnt = 0;
        for (int s = 1; s <= 20; s++) begin
            step("hold_limit", 4'b0001, 4'b0000);
            if (s <= 19 && ldbus_o == 4'b0001) ld_cnt++;
            if (timeout_o) to_cnt++;
            if (s == 18) check("timeout_pulse", 32'(timeout_o), 32'd1);
            if (s == 20) check("regrant0", 32'({gnt_o, ldbus_o}), 32'({4'b0001, 4'b0000}));
        end
        check("hold_cycles", 32'(ld_cnt), 32'd16);
        check("timeout_count", 32'(to_cnt), 32'd1);

        // DONE on the final allowed OWN cycle suppresses TIMEOUT
        do_reset();
        for (int s = 1; s <= 18; s++) begin
            step("done_at_limit", 4'b0001, (s == 18) ? 4'b0001 : 4'b0000);
            if (s == 18) check("no_timeout", 32'({timeout_o, busy_o, gnt_o}), 32'({1'b0, 1'b1, 4'b0000}));
        end

        // Asynchronous reset while owner 2 drives the bus
        do_reset();
        step("pre_rst_grant", 4'b0100, 4'b0000);
        step("pre_rst_own", 4'b0100, 4'b0000);
        check("pre_rst_ldbus", 32'(ldbus_o), 32'(4'b0100));
        rst_n = 1'b0;
        #1;
        check("async_rst", pack_dut(), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_grant", 4'b0100, 4'b0000);
        check("post_rst_id", 32'({gnt_o, gnt_id_o}), 32'({4'b0100, 2'd2}));

        // Random traffic with sticky requests against the model
        do_reset();
        rr = '0;
        for (int s = 0; s < 1500; s++) begin
            for (int b = 0; b < NREQ; b++) begin
                if ($urandom_range(0, 4) == 0) rr[b] = ~rr[b];
            end
            dd = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '0;
            step("random", rr, dd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
